// File: rtl/lpf_env_detect.sv
// rtl/lpf_env_detect.sv - hysteretic envelope detector with hold qualification, event counter and peak capture
// Debounces threshold crossings of the low-pass magnitude into on/off events.
module lpf_env_detect #(
  parameter logic [7:0]  TH_HI = 8'd64,
  parameter logic [7:0]  TH_LO = 8'd32,
  parameter int unsigned HOLD  = 4
) (
  input  logic              clk60kHz,
  input  logic              rst_n,
  input  logic signed [8:0] in,
  input  logic              clear,
  output logic              active,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic [7:0]        event_cnt,
  output logic [7:0]        peak
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_ACT  = 2'd2,
    S_REL  = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  state_t     state, state_nxt;
  logic [7:0] hcnt, hcnt_nxt;
  logic [7:0] run, run_nxt, run_max;
  logic [8:0] neg_in;
  logic [7:0] mag;
  logic       hi, lo;
  logic       active_nxt, rise_nxt, fall_nxt, done;

  // |in| as 8 bits; -256 is the only value whose magnitude does not fit
  assign neg_in = -in;
  always_comb begin
    mag = in[7:0];
    if (in[8]) begin
      mag = neg_in[8] ? 8'hFF : neg_in[7:0];
    end
  end

  assign hi      = (mag >= TH_HI);
  assign lo      = (mag < TH_LO);
  assign run_max = (mag > run) ? mag : run;

  always_ff @(posedge clk60kHz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      hcnt       <= 8'd0;
      run        <= 8'd0;
      active     <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      hcnt       <= hcnt_nxt;
      run        <= run_nxt;
      active     <= active_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    run_nxt   = run;
    case (state)
      S_IDLE: begin
        if (hi) begin
          state_nxt = S_ARM;
          hcnt_nxt  = 8'd1;
          run_nxt   = mag;
        end
      end
      S_ARM: begin
        run_nxt = run_max;
        if (!hi) begin
          state_nxt = S_IDLE;
          hcnt_nxt  = 8'd0;
        end else if (hcnt == HOLD_M1) begin
          state_nxt = S_ACT;
          hcnt_nxt  = 8'd0;
        end else begin
          hcnt_nxt = hcnt + 8'd1;
        end
      end
      S_ACT: begin
        run_nxt = run_max;
        if (lo) begin
          state_nxt = S_REL;
          hcnt_nxt  = 8'd1;
        end
      end
      S_REL: begin
        run_nxt = run_max;
        if (!lo) begin
          state_nxt = S_ACT;
          hcnt_nxt  = 8'd0;
        end else if (hcnt == HOLD_M1) begin
          state_nxt = S_IDLE;
          hcnt_nxt  = 8'd0;
        end else begin
          hcnt_nxt = hcnt + 8'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        hcnt_nxt  = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they register on the same edge as the transition
  always_comb begin
    active_nxt = (state_nxt == S_ACT) || (state_nxt == S_REL);
    rise_nxt   = (state == S_ARM) && (state_nxt == S_ACT);
    done       = (state == S_REL) && (state_nxt == S_IDLE);
    fall_nxt   = done;
  end

  // clear has priority over a completing event but leaves the FSM alone
  always_ff @(posedge clk60kHz or negedge rst_n) begin
    if (!rst_n) begin
      event_cnt <= 8'd0;
      peak      <= 8'd0;
    end else if (clear) begin
      event_cnt <= 8'd0;
      peak      <= 8'd0;
    end else if (done) begin
      event_cnt <= event_cnt + 8'd1;
      peak      <= run_max;
    end
  end

endmodule

// File: tb/tb_lpf_env_detect.sv
// tb/tb_lpf_env_detect.sv - self-checking bench for lpf_env_detect
// Segment table plus per-cycle scoreboard fed by a behavioural run-length model.
module tb_lpf_env_detect;

  localparam int TH_HI = 64;
  localparam int TH_LO = 32;
  localparam int HOLD  = 4;

  logic              clk60kHz = 1'b0;
  logic              rst_n;
  logic signed [8:0] in_s;
  logic              clear;
  logic              active, rise_pulse, fall_pulse;
  logic [7:0]        event_cnt, peak;

  lpf_env_detect #(.TH_HI(8'(TH_HI)), .TH_LO(8'(TH_LO)), .HOLD(HOLD)) dut (
    .clk60kHz  (clk60kHz),
    .rst_n     (rst_n),
    .in        (in_s),
    .clear     (clear),
    .active    (active),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .event_cnt (event_cnt),
    .peak      (peak)
  );

  always #10 clk60kHz = ~clk60kHz;

  typedef struct {
    int active;
    int rise;
    int fall;
    int cnt;
    int peak;
  } exp_t;

  typedef struct {
    int val;
    int cycles;
    int clr;
    int exp_active;
    int exp_cnt;
    int exp_peak;
  } seg_t;

  exp_t sb[$];
  seg_t segs[$];
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   rise_cyc = -1;
  int   fall_cyc = -1;
  int   base;

  // model: run lengths of qualifying samples rather than an explicit state machine
  int         m_active, m_hi, m_lo, m_run, m_peak;
  logic [7:0] m_cnt;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic int mag_of(input int v);
    if (v <= -256) return 255;
    if (v < 0) return -v;
    return v;
  endfunction

  task automatic model_reset();
    m_active = 0; m_hi = 0; m_lo = 0; m_run = 0; m_peak = 0; m_cnt = 8'd0;
  endtask

  task automatic model_step(input int mag, input int clr, output exp_t e);
    int old;
    old = m_active;
    if (m_active == 0) begin
      if (mag >= TH_HI) begin
        m_run = (m_hi == 0) ? mag : ((mag > m_run) ? mag : m_run);
        m_hi++;
        if (m_hi == HOLD) begin m_active = 1; m_hi = 0; m_lo = 0; end
      end else m_hi = 0;
    end else begin
      if (mag > m_run) m_run = mag;
      if (mag < TH_LO) begin
        m_lo++;
        if (m_lo == HOLD) begin
          m_active = 0; m_lo = 0; m_cnt = m_cnt + 8'd1; m_peak = m_run;
        end
      end else m_lo = 0;
    end
    if (clr != 0) begin m_cnt = 8'd0; m_peak = 0; end
    e.active = m_active;
    e.rise   = (m_active == 1 && old == 0) ? 1 : 0;
    e.fall   = (m_active == 0 && old == 1) ? 1 : 0;
    e.cnt    = int'(m_cnt);
    e.peak   = m_peak;
  endtask

  task automatic step(input int v, input int clr);
    exp_t e;
    in_s  = 9'(v);
    clear = (clr != 0);
    model_step(mag_of(v), clr, e);
    sb.push_back(e);
    @(posedge clk60kHz);
    #1;
    cyc++;
    if (rise_pulse) rise_cyc = cyc;
    if (fall_pulse) fall_cyc = cyc;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check($sformatf("active@%0d", cyc), int'(active), e.active);
      check($sformatf("rise@%0d", cyc), int'(rise_pulse), e.rise);
      check($sformatf("fall@%0d", cyc), int'(fall_pulse), e.fall);
      check($sformatf("cnt@%0d", cyc), int'(event_cnt), e.cnt);
      check($sformatf("peak@%0d", cyc), int'(peak), e.peak);
    end
    clear = 1'b0;
  endtask

  task automatic run(input int v, input int n);
    for (int k = 0; k < n; k++) step(v, 0);
  endtask

  task automatic add_seg(input int v, input int n, input int c, input int a, input int ec, input int ep);
    seg_t s;
    s.val = v; s.cycles = n; s.clr = c; s.exp_active = a; s.exp_cnt = ec; s.exp_peak = ep;
    segs.push_back(s);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_active"}, int'(active), 0);
    check({tag, "_rise"}, int'(rise_pulse), 0);
    check({tag, "_fall"}, int'(fall_pulse), 0);
    check({tag, "_cnt"}, int'(event_cnt), 0);
    check({tag, "_peak"}, int'(peak), 0);
  endtask

  initial begin
    //      val   n  clr act cnt peak
    add_seg(   0,  1, 1, 0, 0,   0);  // clear after step test
    add_seg( 100,  3, 0, 0, 0,   0);  // glitch too short
    add_seg(   0,  4, 0, 0, 0,   0);
    add_seg( 100,  6, 0, 1, 0,   0);  // hysteresis
    add_seg(  40, 20, 0, 1, 0,   0);
    add_seg(  10,  3, 0, 1, 0,   0);
    add_seg(  10,  1, 0, 0, 1, 100);
    add_seg(-256,  5, 0, 1, 1, 100);  // saturation
    add_seg(   0,  5, 0, 0, 2, 255);
    add_seg( -70,  4, 0, 1, 2, 255);
    add_seg( -20,  4, 0, 0, 3,  70);
    add_seg(  63,  5, 0, 0, 3,  70);  // just below TH_HI
    add_seg(  64,  4, 0, 1, 3,  70);  // exactly TH_HI
    add_seg(  32,  5, 0, 1, 3,  70);  // exactly TH_LO keeps active
    add_seg(  31,  4, 0, 0, 4,  64);
    add_seg( 200,  2, 0, 0, 4,  64);  // arm then abort
    add_seg(   0,  1, 0, 0, 4,  64);
    add_seg(  80,  4, 0, 1, 4,  64);
    add_seg(   0,  4, 0, 0, 5,  80);  // peak reloaded after abort
    add_seg( 100,  4, 0, 1, 5,  80);
    add_seg(   0,  3, 0, 1, 5,  80);
    add_seg(  50,  1, 0, 1, 5,  80);  // release bounce back to active
    add_seg(   0,  3, 0, 1, 5,  80);
    add_seg(   0,  1, 0, 0, 6, 100);
    add_seg( 100,  4, 0, 1, 6, 100);
    add_seg( 100,  1, 1, 1, 0,   0);  // clear while active
    add_seg(   0,  3, 0, 1, 0,   0);
    add_seg(   0,  1, 1, 0, 0,   0);  // clear on the release edge
    add_seg(-255,  4, 0, 1, 0,   0);
    add_seg(   0,  4, 0, 0, 1, 255);

    rst_n = 1'b0; clear = 1'b0; in_s = '0;
    model_reset();
    #25;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // step test: rise on the 4th high sample, fall on the 4th low one
    base = cyc;
    run(100, 10);
    check("step_rise_latency", rise_cyc - base, 4);
    base = cyc;
    run(0, 10);
    check("step_fall_latency", fall_cyc - base, 4);
    check("step_cnt", int'(event_cnt), 1);
    check("step_peak", int'(peak), 100);

    for (int s = 0; s < segs.size(); s++) begin
      for (int k = 0; k < segs[s].cycles; k++)
        step(segs[s].val, (k == segs[s].cycles - 1) ? segs[s].clr : 0);
      check($sformatf("seg%0d_active", s), int'(active), segs[s].exp_active);
      check($sformatf("seg%0d_cnt", s), int'(event_cnt), segs[s].exp_cnt);
      check($sformatf("seg%0d_peak", s), int'(peak), segs[s].exp_peak);
    end

    // reset in the middle of an event
    run(100, 5);
    check("pre_reset_active", int'(active), 1);
    #3 rst_n = 1'b0;
    #1 check_zero_outputs("async_reset");
    model_reset();
    @(posedge clk60kHz);
    #1 check_zero_outputs("held_reset");
    rst_n = 1'b1;
    fall_cyc = -1;
    run(0, 6);
    check("no_fall_after_reset", fall_cyc, -1);
    base = cyc;
    run(100, 4);
    check("post_reset_rise_latency", rise_cyc - base, 4);
    run(0, 4);

    // counter wrap
    step(0, 1);
    for (int n = 0; n < 257; n++) begin
      run(100, 4);
      run(0, 4);
    end
    check("wrap_cnt", int'(event_cnt), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lpf_env_detect.md
LPF_ENV_DETECT -- requirements
Module: lpf_env_detect

Interface
REQ-001 The block SHALL have these parameters: TH_HI, 64, 8-bit unsigned activation threshold on sample magnitude.
REQ-002 The block SHALL have these parameters: TH_LO, 32, 8-bit unsigned release threshold; TH_LO <= TH_HI is required.
REQ-003 The block SHALL have these parameters: HOLD, 4, count of consecutive qualifying samples per transition; legal range 2..255.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk60kHz  input  1  sample clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in  input  9  signed two's-complement sample from the 1.25 kHz low-pass stage, one new sample per clk60kHz cycle.
REQ-007 clear  input  1  synchronous clear of the event counter and peak output.
REQ-008 active  output  1  registered, high while the envelope is considered on.
REQ-009 rise_pulse  output  1  one-cycle pulse on the IDLE/ARM-to-ACTIVE transition.
REQ-010 fall_pulse  output  1  one-cycle pulse on the REL-to-IDLE transition.
REQ-011 event_cnt  output  8  number of completed events, unsigned, wraps 255->0.
REQ-012 peak  output  8  maximum magnitude of the last completed event.

Function
REQ-013 Magnitude SHALL be computed combinationally as mag = |in|, 8-bit unsigned, with -256 saturated to 255.
REQ-014 The FSM SHALL have four states: IDLE, ARM, ACTIVE and REL, plus an 8-bit hold counter hcnt.
REQ-015 IDLE: if mag >= TH_HI, the next state SHALL be ARM and hcnt SHALL become 1; otherwise the state SHALL remain IDLE.
REQ-016 ARM: if mag < TH_HI, the next state SHALL be IDLE and hcnt 0.
REQ-017 ARM: if mag >= TH_HI and hcnt == HOLD-1, the next state SHALL be ACTIVE, with rise_pulse high for the following cycle.
REQ-018 ARM: if mag >= TH_HI and hcnt < HOLD-1, hcnt SHALL increment.
REQ-019 ACTIVE: if mag < TH_LO, the next state SHALL be REL and hcnt SHALL become 1; otherwise the state SHALL remain ACTIVE.
REQ-020 REL: if mag >= TH_LO, the block SHALL return to ACTIVE with hcnt 0 and no pulse.
REQ-021 REL: if mag < TH_LO and hcnt == HOLD-1, the next state SHALL be IDLE, with fall_pulse high for the following cycle and event_cnt incremented.
REQ-022 REL: if mag < TH_LO and hcnt < HOLD-1, hcnt SHALL increment.
REQ-023 active SHALL be high exactly while the state is ACTIVE or REL.
REQ-024 Latency: active SHALL rise at the clock edge that samples the HOLD-th consecutive sample with mag >= TH_HI.
REQ-025 Latency: active SHALL fall at the clock edge that samples the HOLD-th consecutive sample with mag < TH_LO.
REQ-026 An internal 8-bit running maximum SHALL load mag on IDLE->ARM and take max(run, mag) each cycle in ARM, ACTIVE and REL.
REQ-027 peak SHALL load max(run, mag) on the REL->IDLE transition and otherwise hold its value.
REQ-028 An abort from ARM to IDLE SHALL leave peak and event_cnt unchanged.
REQ-029 clear SHALL set event_cnt and peak to 0 on the next edge without affecting the FSM or active.
REQ-030 If clear coincides with a REL->IDLE transition, clear SHALL win (event_cnt = 0, peak = 0), and fall_pulse SHALL still assert.
REQ-031 event_cnt SHALL wrap from 255 to 0 with no flag.
REQ-032 rise_pulse and fall_pulse SHALL never be high in the same cycle.
REQ-033 Each pulse SHALL last exactly one cycle.

Reset
REQ-034 While rst_n = 0, asynchronously: state IDLE, hcnt 0, running max 0, active 0, rise_pulse 0, fall_pulse 0, event_cnt 0, peak 0.
REQ-035 Reset asserted mid-event SHALL abort the event with no fall_pulse and no count increment.
REQ-036 After reset release, the first edge SHALL evaluate as IDLE.

Verification (TH_HI=64, TH_LO=32, HOLD=4)
REQ-037 Step test: in = 100 for 10 cycles, then 0 -> rise_pulse in cycle 4; fall_pulse 4 cycles after the drop; event_cnt=1; peak=100.
REQ-038 Glitch reject: in = 100 for 3 cycles, then 0 -> active never rises; event_cnt=0; peak=0.
REQ-039 Hysteresis: 100 x6, then 40 x20, then 10 x4 -> active stays high through the 40s; fall_pulse after the fourth 10; peak=100.
REQ-040 Negative/saturation: in = -256 x5, then 0 x5 -> one event; peak=255.
REQ-041 Clear collision: clear asserted on the same edge as REL->IDLE -> fall_pulse=1; event_cnt=0; peak=0.
REQ-042 Reset mid-event: rst_n pulled low while ACTIVE -> all outputs 0 immediately; no fall_pulse after release.
